// File: rtl/keccak_padder_if.sv
// Word-stream bus between the input stream, size_counter, keccak_padder and the absorb datapath.
// The slave modport is the padder's view; the master modport is the surrounding logic's view.
interface keccak_padder_if #(
    parameter int w = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [w-1:0]           in_data;
    logic                   last_word;
    logic [$clog2(w)-1:0]   last_word_remainder;
    logic                   count_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [w-1:0]           out_data;
    logic                   out_block_end;
    logic                   out_last;

    modport master (
        output in_valid, in_data, last_word, last_word_remainder, out_ready,
        input  in_ready, count_en, out_valid, out_data, out_block_end, out_last
    );

    modport slave (
        input  in_valid, in_data, last_word, last_word_remainder, out_ready,
        output in_ready, count_en, out_valid, out_data, out_block_end, out_last
    );
endinterface

// File: rtl/keccak_padder.sv
// Keccak message padder: passes message words, masks the final word, applies suffix + pad10*1.
// Optional KECCAK_SHA3_SUFFIX_EN adds sha3_sel to pick the SHA3 suffix instead of SHAKE.
module keccak_padder #(
    parameter int w              = 64,
    parameter int MAX_RATE_WORDS = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       empty_msg,
    input  logic [4:0] rate_words,
`ifdef KECCAK_SHA3_SUFFIX_EN
    input  logic       sha3_sel,
`endif
    keccak_padder_if.slave bus
);
    localparam int IW  = $clog2(MAX_RATE_WORDS + 1);
    localparam int SHW = $clog2(w) + 1;
    localparam int PW  = 5;

    typedef enum logic [1:0] {IDLE, ABSORB, PAD, EXTRA} state_t;

    state_t         state, state_n;
    logic [4:0]     rate_q;
    logic [IW-1:0]  word_idx;
    logic [PW-1:0]  sfx_q, sfx_sel, pend_q, pend_n;
    logic           out_free, blk_end, emit, abort, fin_ctx, last_n;
    logic [SHW-1:0] vb;
    logic [w-1:0]   ones, mask, base, pat_lo, pat_hi, word_n;
    logic [2*w-1:0] sh;

`ifdef KECCAK_SHA3_SUFFIX_EN
    assign sfx_sel = sha3_sel ? 5'b00110 : 5'b11111;
`else
    assign sfx_sel = 5'b11111;
`endif

    always_comb begin
        out_free = !bus.out_valid || bus.out_ready;
        abort    = start && (state != IDLE);
        blk_end  = (word_idx == IW'(rate_q - 5'd1));
        vb       = (bus.last_word_remainder == '0) ? SHW'(w) : {1'b0, bus.last_word_remainder};
        ones     = '1;
        mask     = ones >> (SHW'(w) - vb);
        // Suffix placed right after the valid bits; the upper half is what spills into later words.
        sh       = {{(2*w-PW){1'b0}}, sfx_q} << vb;

        bus.in_ready = (state == ABSORB) && out_free;
        bus.count_en = bus.in_valid && bus.in_ready;

        base    = '0;
        pat_lo  = '0;
        pat_hi  = '0;
        emit    = 1'b0;
        fin_ctx = 1'b0;
        last_n  = 1'b0;
        state_n = state;
        pend_n  = pend_q;

        case (state)
            ABSORB: begin
                emit    = bus.count_en;
                fin_ctx = bus.last_word;
                if (bus.last_word) begin
                    base   = bus.in_data & mask;
                    pat_lo = sh[w-1:0];
                    pat_hi = sh[2*w-1:w];
                end else begin
                    base = bus.in_data;
                end
            end
            PAD, EXTRA: begin
                emit    = out_free;
                fin_ctx = 1'b1;
                pat_lo  = {{(w-PW){1'b0}}, pend_q};
            end
            default: ;
        endcase

        word_n = base | pat_lo;

        if (emit && fin_ctx) begin
            if (!blk_end) begin
                state_n = (state == EXTRA) ? EXTRA : PAD;
                pend_n  = pat_hi[PW-1:0];
            end else if (pat_lo[w-1] || (pat_hi != '0)) begin
                // Suffix reached bit R-1: the closing one moves into an extra block.
                state_n = EXTRA;
                pend_n  = pat_hi[PW-1:0];
            end else begin
                word_n[w-1] = 1'b1;
                last_n      = 1'b1;
                state_n     = IDLE;
                pend_n      = '0;
            end
        end

        if (start) begin
            emit    = 1'b0;
            state_n = empty_msg ? PAD : ABSORB;
            pend_n  = empty_msg ? sfx_sel : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rate_q            <= '0;
            sfx_q             <= '0;
            pend_q            <= '0;
            word_idx          <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_data      <= '0;
            bus.out_block_end <= 1'b0;
            bus.out_last      <= 1'b0;
        end else begin
            state  <= state_n;
            pend_q <= pend_n;
            if (start) begin
                rate_q   <= rate_words;
                sfx_q    <= sfx_sel;
                word_idx <= '0;
            end
            if (abort) begin
                bus.out_valid     <= 1'b0;
                bus.out_data      <= '0;
                bus.out_block_end <= 1'b0;
                bus.out_last      <= 1'b0;
            end else if (emit) begin
                bus.out_valid     <= 1'b1;
                bus.out_data      <= word_n;
                bus.out_block_end <= blk_end;
                bus.out_last      <= last_n;
                word_idx          <= blk_end ? '0 : word_idx + 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keccak_padder.sv
// Directed self-checking bench for keccak_padder (SHAKE suffix, rate 21 words).
module tb_keccak_padder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       empty_msg = 1'b0;
    logic [4:0] rate_words = 5'd21;
`ifdef KECCAK_SHA3_SUFFIX_EN
    logic       sha3_sel = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] got_data[$];
    bit          got_end[$];
    bit          got_last[$];
    int          n_cnt;
    bit          timeout;
    logic [63:0] hold_data[3];
    logic        hold_vld[3];
    logic        hold_rdy[3];
    logic        hold_cnt[3];

    keccak_padder_if #(.w(64)) bus ();

    keccak_padder #(.w(64), .MAX_RATE_WORDS(21)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .empty_msg  (empty_msg),
        .rate_words (rate_words),
`ifdef KECCAK_SHA3_SUFFIX_EN
        .sha3_sel   (sha3_sel),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dword(input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) << 32) | 64'(i);
    endfunction

    // Drives one message (n words, final remainder rem) and records every output transfer.
    task automatic run_msg(input int n, input logic [5:0] rem, input logic [63:0] fin,
                           input bit fill_ones, input int hold_at);
        int  sent = 0;
        int  cyc = 0;
        int  hi = 0;
        bit  done = 0;
        got_data.delete(); got_end.delete(); got_last.delete();
        n_cnt = 0;
        start = 1'b1;
        empty_msg = (n == 0);
        rate_words = 5'd21;
        @(posedge clk); #1;
        start = 1'b0;
        empty_msg = 1'b0;
        while (!done && cyc < 400) begin
            bus.in_valid = (sent < n);
            bus.in_data = (sent == n - 1) ? fin : (fill_ones ? 64'hFFFF_FFFF_FFFF_FFFF : dword(sent));
            bus.last_word = (sent == n - 1);
            bus.last_word_remainder = rem;
            bus.out_ready = !(hold_at >= 0 && cyc >= hold_at && cyc < hold_at + 3);
            @(negedge clk);
            if (!bus.out_ready && hi < 3) begin
                hold_data[hi] = bus.out_data;
                hold_vld[hi] = bus.out_valid;
                hold_rdy[hi] = bus.in_ready;
                hold_cnt[hi] = bus.count_en;
                hi++;
            end
            if (bus.count_en) n_cnt++;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_end.push_back(bus.out_block_end);
                got_last.push_back(bus.out_last);
                if (bus.out_last) done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        timeout = !done;
        bus.in_valid = 1'b0;
        bus.last_word = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        #12;
        checks++;
        if ({bus.out_valid, bus.out_block_end, bus.out_last, bus.in_ready, bus.count_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.out_valid, bus.out_block_end, bus.out_last, bus.in_ready, bus.count_en});
        end
        checks++;
        if (bus.out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", bus.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_empty();
        logic [63:0] exp[$];
        run_msg(0, 6'd0, 64'h0, 0, -1);
        for (int i = 0; i < 21; i++) exp.push_back(64'h0);
        exp[0] = 64'h0000_0000_0000_001F;
        exp[20] = 64'h8000_0000_0000_0000;
        checks++;
        if (timeout || got_data.size() != exp.size()) begin
            errors++;
            $display("FAIL empty_len got=%0d exp=%0d timeout=%0b", got_data.size(), exp.size(), timeout);
        end
        for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
            checks++;
            if (got_data[i] !== exp[i] || got_end[i] !== (i % 21 == 20) || got_last[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL empty_w%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_end[i], got_last[i],
                         exp[i], i % 21 == 20, i == exp.size() - 1);
            end
        end
        checks++;
        if (n_cnt != 0) begin
            errors++;
            $display("FAIL empty_count_en got=%0d exp=0", n_cnt);
        end
    endtask

    task automatic test_one_word();
        logic [63:0] exp[$];
        logic [63:0] src[2];
        src[0] = 64'h0000_0000_0000_00AB;
        src[1] = 64'hDEAD_BEEF_0000_55AB;
        for (int k = 0; k < 2; k++) begin
            run_msg(1, 6'd8, src[k], 0, -1);
            exp.delete();
            for (int i = 0; i < 21; i++) exp.push_back(64'h0);
            exp[0] = 64'h0000_0000_0000_1FAB;
            exp[20] = 64'h8000_0000_0000_0000;
            checks++;
            if (timeout || got_data.size() != exp.size()) begin
                errors++;
                $display("FAIL one_word%0d_len got=%0d exp=%0d timeout=%0b", k, got_data.size(), exp.size(), timeout);
            end
            for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
                checks++;
                if (got_data[i] !== exp[i] || got_end[i] !== (i % 21 == 20) || got_last[i] !== (i == exp.size() - 1)) begin
                    errors++;
                    $display("FAIL one_word%0d_w%0d got=%h/%b/%b exp=%h/%b/%b", k, i, got_data[i], got_end[i],
                             got_last[i], exp[i], i % 21 == 20, i == exp.size() - 1);
                end
            end
        end
    endtask

    task automatic test_straddle();
        logic [63:0] exp[$];
        run_msg(1, 6'd62, 64'h3FFF_FFFF_FFFF_FFFF, 0, -1);
        for (int i = 0; i < 21; i++) exp.push_back(64'h0);
        exp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp[1] = 64'h0000_0000_0000_0007;
        exp[20] = 64'h8000_0000_0000_0000;
        checks++;
        if (timeout || got_data.size() != exp.size()) begin
            errors++;
            $display("FAIL straddle_len got=%0d exp=%0d timeout=%0b", got_data.size(), exp.size(), timeout);
        end
        for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
            checks++;
            if (got_data[i] !== exp[i] || got_end[i] !== (i % 21 == 20) || got_last[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL straddle_w%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_end[i], got_last[i],
                         exp[i], i % 21 == 20, i == exp.size() - 1);
            end
        end
    endtask

    task automatic test_exact_block();
        logic [63:0] exp[$];
        run_msg(21, 6'd0, dword(20), 0, -1);
        for (int i = 0; i < 21; i++) exp.push_back(dword(i));
        for (int i = 0; i < 21; i++) exp.push_back(64'h0);
        exp[21] = 64'h0000_0000_0000_001F;
        exp[41] = 64'h8000_0000_0000_0000;
        checks++;
        if (timeout || got_data.size() != exp.size()) begin
            errors++;
            $display("FAIL exact_len got=%0d exp=%0d timeout=%0b", got_data.size(), exp.size(), timeout);
        end
        for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
            checks++;
            if (got_data[i] !== exp[i] || got_end[i] !== (i % 21 == 20) || got_last[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL exact_w%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_end[i], got_last[i],
                         exp[i], i % 21 == 20, i == exp.size() - 1);
            end
        end
        checks++;
        if (n_cnt != 21) begin
            errors++;
            $display("FAIL exact_count_en got=%0d exp=21", n_cnt);
        end
    endtask

    task automatic test_overflow_boundary();
        logic [63:0] exp[$];
        run_msg(21, 6'd59, 64'hFFFF_FFFF_FFFF_FFFF, 1, -1);
        for (int i = 0; i < 21; i++) exp.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 21; i++) exp.push_back(64'h0);
        exp[41] = 64'h8000_0000_0000_0000;
        checks++;
        if (timeout || got_data.size() != exp.size()) begin
            errors++;
            $display("FAIL ovf_len got=%0d exp=%0d timeout=%0b", got_data.size(), exp.size(), timeout);
        end
        for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
            checks++;
            if (got_data[i] !== exp[i] || got_end[i] !== (i % 21 == 20) || got_last[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL ovf_w%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_end[i], got_last[i],
                         exp[i], i % 21 == 20, i == exp.size() - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp[$];
        run_msg(5, 6'd0, dword(4), 0, 2);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hold_data[k] !== dword(1) || hold_vld[k] !== 1'b1 || hold_rdy[k] !== 1'b0 || hold_cnt[k] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got=%h v=%b rdy=%b cnt=%b exp=%h v=1 rdy=0 cnt=0", k, hold_data[k],
                         hold_vld[k], hold_rdy[k], hold_cnt[k], dword(1));
            end
        end
        for (int i = 0; i < 5; i++) exp.push_back(dword(i));
        for (int i = 5; i < 21; i++) exp.push_back(64'h0);
        exp[5] = 64'h0000_0000_0000_001F;
        exp[20] = 64'h8000_0000_0000_0000;
        checks++;
        if (timeout || got_data.size() != exp.size()) begin
            errors++;
            $display("FAIL bp_len got=%0d exp=%0d timeout=%0b", got_data.size(), exp.size(), timeout);
        end
        for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
            checks++;
            if (got_data[i] !== exp[i] || got_end[i] !== (i % 21 == 20) || got_last[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL bp_w%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_end[i], got_last[i],
                         exp[i], i % 21 == 20, i == exp.size() - 1);
            end
        end
        checks++;
        if (n_cnt != 5) begin
            errors++;
            $display("FAIL bp_count_en got=%0d exp=5", n_cnt);
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        start = 1'b1;
        empty_msg = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        empty_msg = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h1F) begin
            errors++;
            $display("FAIL arst_pre got=v%b %h exp=v1 000000000000001f", bus.out_valid, bus.out_data);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_block_end, bus.out_last, bus.in_ready, bus.count_en} !== 5'b0 ||
            bus.out_data !== 64'h0) begin
            errors++;
            $display("FAIL arst_outputs got=%b %h exp=00000 0",
                     {bus.out_valid, bus.out_block_end, bus.out_last, bus.in_ready, bus.count_en}, bus.out_data);
        end
        checks++;
        if (dut.word_idx !== 5'd0) begin
            errors++;
            $display("FAIL arst_word_idx got=%0d exp=0", dut.word_idx);
        end
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_idle got=v%b rdy%b exp=v0 rdy0", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.last_word = 1'b0;
        bus.last_word_remainder = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_empty();
        test_one_word();
        test_straddle();
        test_exact_block();
        test_overflow_boundary();
        test_backpressure();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
